// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the audio codec init sequencer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package codec_cfg_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } seq_state_t;

  // One init-table entry: the two bytes sent after the device address
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
  } init_entry_t;

  // Default 8-bit I2C write address of the WM8731 (CSB tied low)
  localparam logic [7:0] CODEC_DEV_ADDR = 8'h34;

  // WM8731 7-bit register addresses
  localparam logic [6:0] WM_LLINE_IN    = 7'h00;
  localparam logic [6:0] WM_RLINE_IN    = 7'h01;
  localparam logic [6:0] WM_LHP_OUT     = 7'h02;
  localparam logic [6:0] WM_RHP_OUT     = 7'h03;
  localparam logic [6:0] WM_ANALOG_PATH = 7'h04;
  localparam logic [6:0] WM_POWER_DOWN  = 7'h06;
  localparam logic [6:0] WM_IFACE_FMT   = 7'h07;
  localparam logic [6:0] WM_SAMPLE_CTRL = 7'h08;
  localparam logic [6:0] WM_ACTIVE      = 7'h09;
  localparam logic [6:0] WM_RESET       = 7'h0F;

  // The WM8731 packs a 7-bit register address and a 9-bit value into two
  // bytes: {addr[6:0], value[8]} followed by value[7:0].
  function automatic init_entry_t wm_entry(input logic [6:0] reg_addr,
                                           input logic [8:0] value);
    init_entry_t e;
    e.reg_addr = {reg_addr, value[8]};
    e.wr_data  = value[7:0];
    return e;
  endfunction

  // Bits needed to hold 0..max_val, never less than one bit
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/codec_init_rom.sv
// Combinational WM8731 init table, indexed by entry number.
// Latency: zero cycles (pure lookup).
// Backpressure: none; indices at or above NUM_ENTRIES read as 16'h0000.
module codec_init_rom
  import codec_cfg_pkg::*;
#(
  parameter int NUM_ENTRIES = 10
) (
  input  logic [4:0]  entry_idx,
  output init_entry_t entry
);

  // Table lookup; power-up order: reset, power, inputs, outputs, paths,
  // format, sample rate, and finally activate the digital interface.
  always_comb begin
    entry = '0;
    if (int'(entry_idx) < NUM_ENTRIES) begin
      case (entry_idx)
        5'd0:    entry = wm_entry(WM_RESET,       9'h000);
        5'd1:    entry = wm_entry(WM_POWER_DOWN,  9'h010);
        5'd2:    entry = wm_entry(WM_LLINE_IN,    9'h017);
        5'd3:    entry = wm_entry(WM_RLINE_IN,    9'h017);
        5'd4:    entry = wm_entry(WM_LHP_OUT,     9'h079);
        5'd5:    entry = wm_entry(WM_RHP_OUT,     9'h079);
        5'd6:    entry = wm_entry(WM_ANALOG_PATH, 9'h012);
        5'd7:    entry = wm_entry(WM_IFACE_FMT,   9'h00A);
        5'd8:    entry = wm_entry(WM_SAMPLE_CTRL, 9'h000);
        5'd9:    entry = wm_entry(WM_ACTIVE,      9'h001);
        default: entry = '0;
      endcase
    end
  end

endmodule

// File: rtl/codec_init_sequencer.sv
// Walks the codec init table and issues one I2C register write per entry.
// Latency: LOAD+REQ = 2 clocks to request, then GAP_CYCLES idle between writes.
// Backpressure: waits on i2c_done per write; watchdog to FAIL after TIMEOUT_CYCLES.
// Build option: define CODEC_INIT_RETRY_EN to retry a nacked entry up to MAX_RETRY times.
module codec_init_sequencer
  import codec_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR       = CODEC_DEV_ADDR,
  parameter int         NUM_ENTRIES    = 10,
  parameter int         GAP_CYCLES     = 50,
  parameter int         TIMEOUT_CYCLES = 4095,
  parameter int         MAX_RETRY      = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       i2c_done,
  input  logic [1:0] i2c_status,
  output logic [8:0] i2c_dev_addr,
  output logic [7:0] i2c_reg_addr,
  output logic [7:0] i2c_wr_data,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [4:0] entry_idx
);

  localparam int GAP_W = cnt_width(GAP_CYCLES);
  localparam int WD_W  = cnt_width(TIMEOUT_CYCLES);

  localparam logic [4:0]       LAST_IDX = 5'(NUM_ENTRIES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  seq_state_t       state;
  seq_state_t       state_nxt;
  init_entry_t      rom_entry;
  logic [GAP_W-1:0] gap_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             req;
  logic             in_wait;
  logic             start_acc;
  logic             ack_ok;
  logic             wd_expire;
  logic             gap_end;
  logic             last_entry;
  logic             retry_ok;
  logic             retry_pend;

  // Controller busy flag is informational only; i2c_done alone ends a write
  logic unused_status_busy;
  assign unused_status_busy = i2c_status[0];

  codec_init_rom #(
    .NUM_ENTRIES (NUM_ENTRIES)
  ) u_rom (
    .entry_idx (entry_idx),
    .entry     (rom_entry)
  );

  assign in_wait    = (state == ST_WAIT);
  assign start_acc  = start && ((state == ST_IDLE) || (state == ST_DONE) ||
                                (state == ST_FAIL));
  assign ack_ok     = in_wait && i2c_done && !i2c_status[1];
  // i2c_done wins over a watchdog expiry landing in the same cycle
  assign wd_expire  = in_wait && !i2c_done && (wd_cnt == WD_LAST);
  assign gap_end    = (state == ST_GAP) && (gap_cnt == GAP_LAST);
  assign last_entry = (entry_idx == LAST_IDX);

`ifdef CODEC_INIT_RETRY_EN
  localparam int RTY_W = cnt_width(MAX_RETRY);
  localparam logic [RTY_W-1:0] RTY_MAX = RTY_W'(MAX_RETRY);

  logic [RTY_W-1:0] retry_cnt;
  logic             ack_fail;

  assign ack_fail = in_wait && i2c_done && i2c_status[1];
  assign retry_ok = (retry_cnt < RTY_MAX);

  // Retry bookkeeping: count nacks on the current entry, remember to skip LOAD
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retry_cnt  <= '0;
      retry_pend <= 1'b0;
    end else begin
      if (start_acc || ack_ok) begin
        retry_cnt <= '0;
      end else if (ack_fail && retry_ok) begin
        retry_cnt <= retry_cnt + RTY_W'(1);
      end
      if (ack_fail && retry_ok) begin
        retry_pend <= 1'b1;
      end else if (gap_end) begin
        retry_pend <= 1'b0;
      end
    end
  end
`else
  localparam int unused_max_retry = MAX_RETRY;

  assign retry_ok   = 1'b0;
  assign retry_pend = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: state_nxt = ST_REQ;
      ST_REQ:  state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (i2c_done) begin
          if (!i2c_status[1]) begin
            state_nxt = last_entry ? ST_DONE : ST_GAP;
          end else begin
            state_nxt = retry_ok ? ST_GAP : ST_FAIL;
          end
        end else if (wd_expire) begin
          state_nxt = ST_FAIL;
        end
      end
      ST_GAP: begin
        if (gap_end) state_nxt = retry_pend ? ST_REQ : ST_LOAD;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    error = 1'b0;
    req   = 1'b0;
    case (state)
      ST_LOAD: busy = 1'b1;
      ST_REQ, ST_WAIT: begin
        busy = 1'b1;
        req  = 1'b1;
      end
      ST_GAP:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      ST_FAIL: error = 1'b1;
      default: ;
    endcase
  end

  // Device address only presented while a sequence is active; request bit
  // is state-derived so an async reset removes it at once.
  assign i2c_dev_addr = {req, (busy ? DEV_ADDR : 8'h00)};

  // Entry pointer and latched register/data bytes for the current write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_idx    <= '0;
      i2c_reg_addr <= '0;
      i2c_wr_data  <= '0;
    end else begin
      if (start_acc) begin
        entry_idx <= '0;
      end else if (ack_ok && !last_entry) begin
        entry_idx <= entry_idx + 5'd1;
      end
      if (state == ST_LOAD) begin
        i2c_reg_addr <= rom_entry.reg_addr;
        i2c_wr_data  <= rom_entry.wr_data;
      end
    end
  end

  // Gap timer and WAIT watchdog; both park at zero outside their state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      gap_cnt <= ((state == ST_GAP) && !gap_end) ? gap_cnt + GAP_W'(1) : '0;
      wd_cnt  <= (in_wait && !i2c_done && !wd_expire) ? wd_cnt + WD_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Directed bench for codec_init_sequencer with a hand-driven I2C controller.
// Latency: n/a.
// Backpressure: n/a.
module tb_codec_init_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       i2c_done = 1'b0;
  logic [1:0] i2c_status = 2'b00;
  logic [8:0] i2c_dev_addr;
  logic [7:0] i2c_reg_addr;
  logic [7:0] i2c_wr_data;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] entry_idx;

  // Hand-packed WM8731 bytes: {reg7, value[8]} and value[7:0]
  logic [7:0] exp_reg [10] = '{8'h1E, 8'h0C, 8'h00, 8'h02, 8'h04,
                               8'h06, 8'h08, 8'h0E, 8'h10, 8'h12};
  logic [7:0] exp_dat [10] = '{8'h00, 8'h10, 8'h17, 8'h17, 8'h79,
                               8'h79, 8'h12, 8'h0A, 8'h00, 8'h01};

  int   total = 0;
  int   bad = 0;
  int   rises = 0;
  int   r0;
  int   n;
  logic prev_req = 1'b0;

  always #5 clock = ~clock;

  codec_init_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .i2c_done     (i2c_done),
    .i2c_status   (i2c_status),
    .i2c_dev_addr (i2c_dev_addr),
    .i2c_reg_addr (i2c_reg_addr),
    .i2c_wr_data  (i2c_wr_data),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .entry_idx    (entry_idx)
  );

  // Count request rising edges seen at negedges
  always @(negedge clock) begin
    if (i2c_dev_addr[8] === 1'b1 && prev_req !== 1'b1) rises++;
    prev_req = i2c_dev_addr[8];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_dev_addr", 32'(i2c_dev_addr), 32'h0);
    chk("rst_reg_addr", 32'(i2c_reg_addr), 32'h0);
    chk("rst_wr_data",  32'(i2c_wr_data),  32'h0);
    chk("rst_busy",     32'(busy),         32'h0);
    chk("rst_done",     32'(done),         32'h0);
    chk("rst_error",    32'(error),        32'h0);
    chk("rst_entry",    32'(entry_idx),    32'h0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_req();
    int k = 0;
    while (i2c_dev_addr[8] !== 1'b1 && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("req_rise", 32'(i2c_dev_addr[8]), 32'h1);
  endtask

  // One write: check request contents, answer after 3 cycles with status st
  task automatic serve(input int idx, input logic [1:0] st, input bit poke_start);
    wait_req();
    chk("reg_addr",  32'(i2c_reg_addr), 32'(exp_reg[idx]));
    chk("wr_data",   32'(i2c_wr_data),  32'(exp_dat[idx]));
    chk("dev_addr",  32'(i2c_dev_addr), 32'h134);
    chk("entry_idx", 32'(entry_idx),    idx);
    chk("busy_req",  32'(busy),         32'h1);
    for (int k = 0; k < 3; k++) begin
      start = poke_start && (k == 1);
      @(negedge clock);
    end
    start      = 1'b0;
    i2c_done   = 1'b1;
    i2c_status = st;
    @(negedge clock);
    i2c_done   = 1'b0;
    i2c_status = 2'b00;
    chk("req_drop", 32'(i2c_dev_addr[8]), 32'h0);
  endtask

  // Count low-request cycles until the next request; optionally poke stray inputs
  task automatic gap(input int exp_len, input bit stray);
    int k = 0;
    while (i2c_dev_addr[8] !== 1'b1 && k < 200) begin
      i2c_done   = stray && (k == 10);
      start      = stray && (k == 10);
      i2c_status = (stray && (k == 10)) ? 2'b10 : 2'b00;
      k++;
      @(negedge clock);
    end
    i2c_done   = 1'b0;
    start      = 1'b0;
    i2c_status = 2'b00;
    chk("gap_len", k, exp_len);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timed out");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clock);
    chk_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_busy", 32'(busy), 32'h0);

    // Full clean pass; stray done+start in GAP of entry 1, start in WAIT of entry 4
    r0 = rises;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      serve(i, 2'b00, i == 4);
      if (i < 9) gap(51, i == 1);
    end
    chk("pass_done",   32'(done),      32'h1);
    chk("pass_error",  32'(error),     32'h0);
    chk("pass_entry",  32'(entry_idx), 32'h9);
    chk("pass_busy",   32'(busy),      32'h0);
    chk("pass_rises",  rises - r0,     10);

    // Entry 3 nacked once
    pulse_start();
    chk("restart_done_clr", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      serve(i, 2'b00, 1'b0);
      gap(51, 1'b0);
    end
    serve(3, 2'b10, 1'b0);
`ifdef CODEC_INIT_RETRY_EN
    gap(50, 1'b0);
    for (int i = 3; i < 10; i++) begin
      serve(i, 2'b00, 1'b0);
      if (i < 9) gap(51, 1'b0);
    end
    chk("nack1_done",  32'(done),  32'h1);
    chk("nack1_error", 32'(error), 32'h0);
`else
    chk("nack1_error", 32'(error),           32'h1);
    chk("nack1_entry", 32'(entry_idx),       32'h3);
    chk("nack1_req",   32'(i2c_dev_addr[8]), 32'h0);
    chk("nack1_busy",  32'(busy),            32'h0);
`endif

    // Entry 5 nacked until the sequencer gives up
    pulse_start();
    chk("restart_err_clr",   32'(error),     32'h0);
    chk("restart_entry_clr", 32'(entry_idx), 32'h0);
    for (int i = 0; i < 5; i++) begin
      serve(i, 2'b00, 1'b0);
      gap(51, 1'b0);
    end
`ifdef CODEC_INIT_RETRY_EN
    for (int k = 0; k < 4; k++) begin
      serve(5, 2'b10, 1'b0);
      if (k < 3) gap(50, 1'b0);
    end
`else
    serve(5, 2'b10, 1'b0);
`endif
    chk("nack_error", 32'(error),           32'h1);
    chk("nack_entry", 32'(entry_idx),       32'h5);
    chk("nack_req",   32'(i2c_dev_addr[8]), 32'h0);
    chk("nack_done",  32'(done),            32'h0);

    // Watchdog: request high for 1 REQ cycle plus 4095 WAIT cycles
    pulse_start();
    serve(0, 2'b00, 1'b0);
    gap(51, 1'b0);
    wait_req();
    n = 0;
    while (i2c_dev_addr[8] === 1'b1 && n < 5000) begin
      n++;
      @(negedge clock);
    end
    chk("wd_len",   n,                       4096);
    chk("wd_error", 32'(error),              32'h1);
    chk("wd_entry", 32'(entry_idx),          32'h1);
    chk("wd_req",   32'(i2c_dev_addr[8]),    32'h0);

    // i2c_done on the very cycle the watchdog would fire
    pulse_start();
    serve(0, 2'b00, 1'b0);
    gap(51, 1'b0);
    wait_req();
    repeat (4095) @(negedge clock);
    chk("wd_edge_req", 32'(i2c_dev_addr[8]), 32'h1);
    i2c_done = 1'b1;
    @(negedge clock);
    i2c_done = 1'b0;
    chk("wd_edge_error", 32'(error),           32'h0);
    chk("wd_edge_entry", 32'(entry_idx),       32'h2);
    chk("wd_edge_busy",  32'(busy),            32'h1);
    chk("wd_edge_req0",  32'(i2c_dev_addr[8]), 32'h0);
    gap(51, 1'b0);

    // Reset during WAIT of entry 2
    wait_req();
    chk("mid_entry", 32'(entry_idx), 32'h2);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("post_rst_busy", 32'(busy), 32'h0);
    pulse_start();
    serve(0, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
